// File: rtl/cpu_bus_ram_target.sv
//==============================================================================
// Module      : cpu_bus_ram_target
// Description : Word-addressed on-chip RAM responding to the CPU data-bus
//               request/ready handshake with a configurable wait-state count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_bus_ram_target #(
    parameter int    ADDR_BITS   = 10,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bus_request,
    input  logic        i_bus_rw,
    input  logic [31:0] i_bus_address,
    input  logic [31:0] i_bus_wdata,
    output logic        o_bus_ready,
    output logic [31:0] o_bus_rdata
);

    localparam int         c_depth     = 2 ** ADDR_BITS;
    localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_wait_count;
    logic [31:0]            r_mem [c_depth];

    logic [ADDR_BITS-1:0]   w_word_index;
    logic                   w_access;
    logic                   w_unused_addr_bits;

    assign w_word_index       = i_bus_address[ADDR_BITS+1:2];
    assign w_unused_addr_bits = ^{i_bus_address[1:0], i_bus_address[31:ADDR_BITS+2]};

    // The single edge at which the RAM is touched and inputs are sampled.
    assign w_access = i_bus_request &&
                      (((r_state == ST_IDLE) && (WAIT_STATES == 0)) ||
                       ((r_state == ST_WAIT) && (r_wait_count == 4'd0)));

    // A reset landing on the access edge must not commit the write.
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_access && i_bus_rw) begin
            r_mem[w_word_index] <= i_bus_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_wait_count <= 4'd0;
            o_bus_ready  <= 1'b0;
            o_bus_rdata  <= 32'd0;
        end else begin
            o_bus_ready <= 1'b0;
            if (w_access && !i_bus_rw) begin
                o_bus_rdata <= r_mem[w_word_index];
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_bus_request) begin
                        if (WAIT_STATES == 0) begin
                            o_bus_ready <= 1'b1;
                            r_state     <= ST_RELEASE;
                        end else begin
                            r_wait_count <= c_wait_load;
                            r_state      <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!i_bus_request) begin
                        r_state <= ST_IDLE;
                    end else if (r_wait_count != 4'd0) begin
                        r_wait_count <= r_wait_count - 4'd1;
                    end else begin
                        o_bus_ready <= 1'b1;
                        r_state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Request must be seen low before another transaction may start.
                    if (!i_bus_request) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_ram_target.sv
//==============================================================================
// Module      : tb_cpu_bus_ram_target
// Description : Self-checking bench for cpu_bus_ram_target over three
//               parameterisations sharing one clock and reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_bus_ram_target;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [2:0]       rw;
    logic [2:0]       rdy;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [2:0][31:0] rdata;

    int ab_tab[3] = '{4, 10, 6};
    int ws_tab[3] = '{0, 3, 5};

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl     [3][1024];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;

    cpu_bus_ram_target #(.ADDR_BITS(4), .WAIT_STATES(0)) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_bus_request(req[0]), .i_bus_rw(rw[0]),
        .i_bus_address(addr[0]), .i_bus_wdata(wdata[0]),
        .o_bus_ready(rdy[0]), .o_bus_rdata(rdata[0]));

    cpu_bus_ram_target #(.ADDR_BITS(10), .WAIT_STATES(3)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_bus_request(req[1]), .i_bus_rw(rw[1]),
        .i_bus_address(addr[1]), .i_bus_wdata(wdata[1]),
        .o_bus_ready(rdy[1]), .o_bus_rdata(rdata[1]));

    cpu_bus_ram_target #(.ADDR_BITS(6), .WAIT_STATES(5)) u_dut2 (
        .i_clock(clk), .i_reset(rst), .i_bus_request(req[2]), .i_bus_rw(rw[2]),
        .i_bus_address(addr[2]), .i_bus_wdata(wdata[2]),
        .o_bus_ready(rdy[2]), .o_bus_rdata(rdata[2]));

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          hold;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int word_idx(input int d, input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << ab_tab[d]) - 32'd1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete handshake: latency, single pulse, data and write-side effects.
    task automatic do_txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input bit chk, input logic [31:0] exp_rd);
        int          n;
        logic [31:0] e;
        req[d]   = 1'b1;
        rw[d]    = wr;
        addr[d]  = a;
        wdata[d] = wd;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rdy[d] && n < 40);
        check($sformatf("latency_d%0d", d), n, ws_tab[d] + 1);
        if (rdy[d]) begin
            if (wr) begin
                mdl[d][word_idx(d, a)] = wd;
                check($sformatf("rdata_held_on_write_d%0d", d), rdata[d], last_rd[d]);
            end else begin
                e = chk ? exp_rd : mdl[d][word_idx(d, a)];
                check($sformatf("rdata_d%0d_a%h", d, a), rdata[d], e);
                last_rd[d] = e;
            end
        end
        for (int i = 0; i < hold; i++) begin
            wdata[d] = ~wd;
            tick();
            check($sformatf("sticky_no_ready_d%0d", d), {31'd0, rdy[d]}, 32'd0);
        end
        req[d]   = 1'b0;
        wdata[d] = ~wd;
        tick();
        check($sformatf("ready_single_pulse_d%0d", d), {31'd0, rdy[d]}, 32'd0);
    endtask

    function automatic logic [31:0] rand_alias(input int d, input int idx);
        logic [31:0] mask;
        mask = (32'd1 << (ab_tab[d] + 2)) - 32'd1;
        return ($urandom & ~mask) | (32'(idx) << 2) | ($urandom & 32'd3);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 1'b1, 32'h40, 32'hDEADBEEF, 0, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h40, 32'h0,        0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 32'h44, 32'hCAFEF00D, 0, 1'b0, 32'h0};
        vecs[3]  = '{0, 1'b0, 32'h07, 32'h0,        0, 1'b1, 32'hCAFEF00D};
        vecs[4]  = '{1, 1'b1, 32'h100, 32'h12345678, 10, 1'b0, 32'h0};
        vecs[5]  = '{1, 1'b0, 32'h100, 32'h0,       10, 1'b1, 32'h12345678};
        vecs[6]  = '{1, 1'b1, 32'h10, 32'h11223344, 0, 1'b0, 32'h0};
        vecs[7]  = '{1, 1'b0, 32'h10, 32'h0,        0, 1'b1, 32'h11223344};
        vecs[8]  = '{1, 1'b1, 32'h10, 32'h1122AA44, 0, 1'b0, 32'h0};
        vecs[9]  = '{1, 1'b0, 32'h10, 32'h0,        0, 1'b1, 32'h1122AA44};
        vecs[10] = '{2, 1'b1, 32'h20, 32'hA5A55A5A, 0, 1'b0, 32'h0};
        vecs[11] = '{2, 1'b0, 32'h20, 32'h0,        0, 1'b1, 32'hA5A55A5A};

        rst   = 1'b1;
        req   = '0;
        rw    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ready_d%0d", d), {31'd0, rdy[d]}, 32'd0);
            check($sformatf("reset_rdata_d%0d", d), rdata[d], 32'd0);
            last_rd[d] = 32'd0;
        end
        tick();

        for (int v = 0; v < 12; v++) begin
            do_txn(vecs[v].d, vecs[v].wr, vecs[v].a, vecs[v].wd, vecs[v].hold, vecs[v].chk, vecs[v].exp);
        end

        // Give indices 0..15 a known value on every instance, through aliased addresses.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_txn(d, 1'b1, rand_alias(d, i), $urandom, 0, 1'b0, 32'h0);
            end
        end

        for (int k = 0; k < 60; k++) begin
            for (int d = 0; d < 3; d++) begin
                do_txn(d, 1'($urandom_range(0, 1)), rand_alias(d, $urandom_range(0, 15)),
                       $urandom, $urandom_range(0, 2), 1'b0, 32'h0);
            end
        end

        // Abort by dropping request during the wait phase.
        req[2] = 1'b1; rw[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hBAD0BAD0;
        repeat (3) begin
            tick();
            check("abort_no_ready", {31'd0, rdy[2]}, 32'd0);
        end
        req[2] = 1'b0;
        repeat (3) begin
            tick();
            check("abort_idle_no_ready", {31'd0, rdy[2]}, 32'd0);
        end
        do_txn(2, 1'b0, 32'h20, 32'h0, 0, 1'b0, 32'h0);

        // Reset arriving exactly on the would-be access edge of a write.
        req[2] = 1'b1; rw[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h0BADF00D;
        repeat (5) begin
            tick();
            check("pre_reset_no_ready", {31'd0, rdy[2]}, 32'd0);
        end
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        req[2] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("midreset_ready_d%0d", d), {31'd0, rdy[d]}, 32'd0);
            check($sformatf("midreset_rdata_d%0d", d), rdata[d], 32'd0);
            last_rd[d] = 32'd0;
        end
        tick();
        check("post_reset_no_ready", {31'd0, rdy[2]}, 32'd0);
        do_txn(2, 1'b0, 32'h20, 32'h0, 0, 1'b0, 32'h0);
        do_txn(2, 1'b1, 32'h24, 32'h600DCAFE, 0, 1'b0, 32'h0);
        do_txn(2, 1'b0, 32'h24, 32'h0, 0, 1'b1, 32'h600DCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
